cpu_sequencer: RTL

- Parametrised multicycle control sequencer for the Free-Board CPU datapath.
- Drives the fetch / latch / execute / memory-wait / PC-update cycle. Generates memory, register-file, instruction-register and PC enables from the decoded instruction class.
- Arbitrates the shared memory against the display via a freeze input.
- Over the previous sequencer, adds: configurable memory latency, a start/halt state, active-high write enables, a load writeback state and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/seq_wait_counter.sv | 29 ++
 rtl/cpu_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the Free-Board CPU multicycle sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_MEM   = 3'd4,
    ST_PCUPD = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

  localparam logic [1:0] ITYPE_R  = 2'd0;
  localparam logic [1:0] ITYPE_I  = 2'd1;
  localparam logic [1:0] ITYPE_LS = 2'd2;
  localparam logic [1:0] ITYPE_J  = 2'd3;

  localparam logic LS_LOAD  = 1'b0;
  localparam logic LS_STORE = 1'b1;

  function automatic logic is_load(input logic [1:0] itype, input logic ls);
    return (itype == ITYPE_LS) && (ls == LS_LOAD);
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Memory-latency wait counter shared by the FETCH and MEM states.
module seq_wait_counter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic done
);

  localparam int unsigned W = $clog2(MEM_LAT) + 1;
  localparam logic [W-1:0] LAST = W'(MEM_LAT - 1);

  logic [W-1:0] cnt;

  // hold outranks clear so a frozen final wait cycle is replayed intact
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!hold) begin
      if (clear) cnt <= '0;
      else       cnt <= cnt + W'(1);
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle fetch/latch/execute/memory/PC-update control sequencer with
// display-bus freeze, halt/start control and a retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned CNT_W     = 16,
  parameter bit          START_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             bus_stall,
  input  logic [1:0]       instr_type,
  input  logic             load_store,
  output logic             mem_en,
  output logic             mem_write,
  output logic             addr_sel,
  output logic             mem_to_reg,
  output logic             ir_load,
  output logic             reg_we,
  output logic             pc_en,
  output logic             busy,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  localparam state_t RESET_ST = START_RUN ? ST_FETCH : ST_IDLE;

  state_t state_q, state_d;
  logic   active, stall, counting, wait_done, cnt_clear;

  assign active    = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                     (state_q == ST_EXEC)  || (state_q == ST_MEM)   ||
                     (state_q == ST_PCUPD);
  assign stall     = bus_stall && active;
  assign counting  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign cnt_clear = !counting || wait_done;
  assign busy      = active;
  assign state_o   = state_q;

  seq_wait_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .hold (stall),
    .done (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_ST;
      retired <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      if (state_q == ST_PCUPD) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_en     = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    mem_to_reg = 1'b0;
    ir_load    = 1'b0;
    reg_we     = 1'b0;
    pc_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_en   = 1'b1;
        addr_sel = 1'b1;
        if (wait_done) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        ir_load = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_PCUPD;
        case (instr_type)
          ITYPE_R, ITYPE_I: reg_we = 1'b1;
          ITYPE_LS: begin
            mem_en = 1'b1;
            if (load_store == LS_STORE) mem_write = 1'b1;
            else                        state_d   = ST_MEM;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_en = 1'b1;
        if (wait_done) state_d = ST_PCUPD;
      end
      ST_PCUPD: begin
        pc_en = 1'b1;
        if (is_load(instr_type, load_store)) begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
        end
        state_d = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    // display owns the bus: strobes drop, address/writeback selects stay put
    if (stall) begin
      mem_en    = 1'b0;
      mem_write = 1'b0;
      ir_load   = 1'b0;
      reg_we    = 1'b0;
      pc_en     = 1'b0;
    end
  end

endmodule
